// File: rtl/simmem_release_arbiter.sv
// simmem_release_arbiter: picks one release-enabled response slot per cycle, keeping AXI same-ID
// order by slot age. Define SIMMEM_RELEASE_RR_EN for round-robin selection among candidates.
//
// state | meaning
// IDLE  | nothing presented, rel_valid_o low
// HOLD  | slot held in rel_addr_q/rel_id_q until rel_ready_i
module simmem_release_arbiter #(
    parameter int unsigned Capacity = 16,
    parameter int unsigned IdWidth  = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_valid_i,
    input  logic [Capacity-1:0] alloc_addr_onehot_i,
    input  logic [IdWidth-1:0]  alloc_id_i,
    output logic [Capacity-1:0] free_slots_o,
    input  logic [Capacity-1:0] release_en_mhot_i,
    output logic                rel_valid_o,
    input  logic                rel_ready_i,
    output logic [Capacity-1:0] rel_addr_onehot_o,
    output logic [IdWidth-1:0]  rel_id_o,
    output logic [Capacity-1:0] released_addr_onehot_o,
    output logic                alloc_err_o
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [Capacity-1:0] valid_q, valid_d;
    logic [IdWidth-1:0]  id_q  [Capacity];
    logic [IdWidth-1:0]  id_d  [Capacity];
    logic [Capacity-1:0] age_q [Capacity];  // age_q[s][j] set: slot j is older than slot s
    logic [Capacity-1:0] age_d [Capacity];
    logic [Capacity-1:0] rel_addr_q, rel_addr_d;
    logic [IdWidth-1:0]  rel_id_q, rel_id_d;
    logic [Capacity-1:0] released_q, released_d;
    logic                alloc_err_q, alloc_err_d;

    logic                handshake;
    logic                alloc_ok;
    logic [Capacity-1:0] released_now, presented, live, blocked, cand, sel;

    assign handshake    = (state_q == ST_HOLD) && rel_ready_i;
    assign released_now = handshake ? rel_addr_q : '0;
    assign presented    = (state_q == ST_HOLD) ? rel_addr_q : '0;
    assign live         = valid_q & ~released_now;
    assign alloc_ok     = alloc_valid_i && ((alloc_addr_onehot_i & valid_q) == '0);

    // The slot leaving on this handshake no longer blocks its younger same-ID successor.
    always_comb begin
        blocked = '0;
        for (int s = 0; s < Capacity; s++) begin
            for (int j = 0; j < Capacity; j++) begin
                if (live[j] && age_q[s][j] && (id_q[j] == id_q[s])) begin
                    blocked[s] = 1'b1;
                end
            end
        end
    end

    assign cand = valid_q & release_en_mhot_i & ~presented & ~blocked;

`ifdef SIMMEM_RELEASE_RR_EN
    localparam int unsigned IdxW = (Capacity > 1) ? $clog2(Capacity) : 1;

    logic [IdxW-1:0] rr_q, rr_d;

    function automatic logic [IdxW-1:0] onehot_idx(input logic [Capacity-1:0] oh);
        logic [IdxW-1:0] idx;
        idx = '0;
        for (int i = 0; i < Capacity; i++) begin
            if (oh[i]) idx = IdxW'(i);
        end
        return idx;
    endfunction

    function automatic logic [Capacity-1:0] rr_pick(input logic [Capacity-1:0] c,
                                                    input logic [IdxW-1:0]     ptr);
        logic [Capacity-1:0] r;
        logic                found;
        int                  k;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < Capacity; i++) begin
            k = (int'(ptr) + i) % Capacity;
            if (!found && c[k]) begin
                r[k]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        rr_d = rr_q;
        if (handshake) rr_d = IdxW'((int'(onehot_idx(rel_addr_q)) + 1) % Capacity);
    end

    assign sel = rr_pick(cand, rr_d);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_q <= '0;
        else         rr_q <= rr_d;
    end
`else
    always_comb begin
        sel = '0;
        for (int s = 0; s < Capacity; s++) begin
            sel[s] = cand[s] && ((cand & age_q[s]) == '0);
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        rel_addr_d = rel_addr_q;
        rel_id_d   = rel_id_q;
        released_d = released_now;
        if ((state_q == ST_IDLE) || handshake) begin
            if (cand != '0) begin
                state_d    = ST_HOLD;
                rel_addr_d = sel;
                rel_id_d   = '0;
                for (int s = 0; s < Capacity; s++) begin
                    if (sel[s]) rel_id_d = id_q[s];
                end
            end else begin
                state_d    = ST_IDLE;
                rel_addr_d = '0;
                rel_id_d   = '0;
            end
        end
    end

    always_comb begin
        valid_d     = live;
        alloc_err_d = alloc_err_q | (alloc_valid_i && !alloc_ok);
        for (int s = 0; s < Capacity; s++) begin
            id_d[s]  = id_q[s];
            age_d[s] = age_q[s] & ~released_now;
            if (alloc_ok && alloc_addr_onehot_i[s]) begin
                valid_d[s] = 1'b1;
                id_d[s]    = alloc_id_i;
                age_d[s]   = live;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            rel_addr_q  <= '0;
            rel_id_q    <= '0;
            released_q  <= '0;
            alloc_err_q <= 1'b0;
            for (int s = 0; s < Capacity; s++) begin
                id_q[s]  <= '0;
                age_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            rel_addr_q  <= rel_addr_d;
            rel_id_q    <= rel_id_d;
            released_q  <= released_d;
            alloc_err_q <= alloc_err_d;
            for (int s = 0; s < Capacity; s++) begin
                id_q[s]  <= id_d[s];
                age_q[s] <= age_d[s];
            end
        end
    end

    assign free_slots_o           = ~valid_q;
    assign rel_valid_o            = (state_q == ST_HOLD);
    assign rel_addr_onehot_o      = rel_addr_q;
    assign rel_id_o               = rel_id_q;
    assign released_addr_onehot_o = released_q;
    assign alloc_err_o            = alloc_err_q;

endmodule

// File: tb/tb_simmem_release_arbiter.sv
// Bench for simmem_release_arbiter: directed scenarios with literal expectations, then random
// traffic compared every cycle against a timestamp-ordered slot model.
module tb_simmem_release_arbiter;
    localparam int C = 16;
    localparam int W = 4;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           alloc_valid_i;
    logic [C-1:0]   alloc_addr_onehot_i;
    logic [W-1:0]   alloc_id_i;
    logic [C-1:0]   free_slots_o;
    logic [C-1:0]   release_en_mhot_i;
    logic           rel_valid_o;
    logic           rel_ready_i;
    logic [C-1:0]   rel_addr_onehot_o;
    logic [W-1:0]   rel_id_o;
    logic [C-1:0]   released_addr_onehot_o;
    logic           alloc_err_o;

    always #5 clk_i = ~clk_i;

    simmem_release_arbiter #(.Capacity(C), .IdWidth(W)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .alloc_valid_i         (alloc_valid_i),
        .alloc_addr_onehot_i   (alloc_addr_onehot_i),
        .alloc_id_i            (alloc_id_i),
        .free_slots_o          (free_slots_o),
        .release_en_mhot_i     (release_en_mhot_i),
        .rel_valid_o           (rel_valid_o),
        .rel_ready_i           (rel_ready_i),
        .rel_addr_onehot_o     (rel_addr_onehot_o),
        .rel_id_o              (rel_id_o),
        .released_addr_onehot_o(released_addr_onehot_o),
        .alloc_err_o           (alloc_err_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: slots ordered by allocation timestamp rather than an age matrix.
    bit         m_valid [C];
    int         m_id    [C];
    int         m_ts    [C];
    int         ts_ctr;
    bit         m_hold;
    int         m_slot;
    int         m_rel_id;
    logic [C-1:0] m_pulse;
    bit         m_err;
    int         m_rr;

    function automatic logic [C-1:0] onehot(input int i);
        logic [C-1:0] v;
        v = '0;
        if (i >= 0 && i < C) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [C-1:0] m_free();
        logic [C-1:0] f;
        for (int i = 0; i < C; i++) f[i] = !m_valid[i];
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < C; i++) begin
            m_valid[i] = 1'b0;
            m_id[i]    = 0;
            m_ts[i]    = 0;
        end
        ts_ctr   = 0;
        m_hold   = 1'b0;
        m_slot   = -1;
        m_rel_id = 0;
        m_pulse  = '0;
        m_err    = 1'b0;
        m_rr     = 0;
    endtask

    task automatic model_step();
        bit hs;
        bit cand [C];
        int pick;
        int ptr;
        int old_slot;
        bit occ;
        hs       = m_hold && (rel_ready_i === 1'b1);
        old_slot = m_slot;
        for (int s = 0; s < C; s++) begin
            cand[s] = m_valid[s] && release_en_mhot_i[s] && !(m_hold && m_slot == s);
            for (int j = 0; j < C; j++) begin
                if (cand[s] && m_valid[j] && !(hs && j == old_slot) &&
                    m_id[j] == m_id[s] && m_ts[j] < m_ts[s])
                    cand[s] = 1'b0;
            end
        end
        ptr  = hs ? (old_slot + 1) % C : m_rr;
        pick = -1;
`ifdef SIMMEM_RELEASE_RR_EN
        for (int i = 0; i < C; i++) begin
            if (pick < 0 && cand[(ptr + i) % C]) pick = (ptr + i) % C;
        end
`else
        for (int s = 0; s < C; s++) begin
            if (cand[s] && (pick < 0 || m_ts[s] < m_ts[pick])) pick = s;
        end
`endif
        m_rr    = ptr;
        m_pulse = hs ? onehot(old_slot) : '0;
        if (!m_hold || hs) begin
            if (pick >= 0) begin
                m_hold   = 1'b1;
                m_slot   = pick;
                m_rel_id = m_id[pick];
            end else begin
                m_hold = 1'b0;
                m_slot = -1;
            end
        end
        occ = 1'b0;
        for (int s = 0; s < C; s++) begin
            if (alloc_valid_i && alloc_addr_onehot_i[s] && m_valid[s]) occ = 1'b1;
        end
        if (hs) m_valid[old_slot] = 1'b0;
        if (alloc_valid_i) begin
            if (occ) m_err = 1'b1;
            else begin
                for (int s = 0; s < C; s++) begin
                    if (alloc_addr_onehot_i[s]) begin
                        m_valid[s] = 1'b1;
                        m_id[s]    = int'(alloc_id_i);
                        m_ts[s]    = ts_ctr;
                        ts_ctr++;
                    end
                end
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("rel_valid", rel_valid_o, m_hold);
            chk("free_slots", free_slots_o, m_free());
            chk("released", released_addr_onehot_o, m_pulse);
            chk("alloc_err", alloc_err_o, m_err);
            if (m_hold) begin
                chk("rel_addr", rel_addr_onehot_o, onehot(m_slot));
                chk("rel_id", rel_id_o, m_rel_id);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        model_step();
    endtask

    task automatic clear_inputs();
        alloc_valid_i       = 1'b0;
        alloc_addr_onehot_i = '0;
        alloc_id_i          = '0;
        release_en_mhot_i   = '0;
        rel_ready_i         = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
    endtask

    task automatic alloc(input int slot, input int id);
        alloc_valid_i       = 1'b1;
        alloc_addr_onehot_i = onehot(slot);
        alloc_id_i          = W'(id);
        tick();
        alloc_valid_i       = 1'b0;
        alloc_addr_onehot_i = '0;
    endtask

    int tgt;
    int start;

    initial begin
        // Same-ID blocking and back-to-back same-ID release
        do_reset();
        chk("rst_free", free_slots_o, 16'hFFFF);
        chk("rst_valid", rel_valid_o, 1'b0);
        chk("rst_released", released_addr_onehot_o, 16'h0000);
        chk("rst_err", alloc_err_o, 1'b0);
        alloc(0, 3);
        alloc(1, 3);
        alloc(2, 5);
        release_en_mhot_i = 16'h0002;
        rel_ready_i       = 1'b1;
        tick();
        tick();
        chk("blocked_by_older", rel_valid_o, 1'b0);
        release_en_mhot_i = 16'h0003;
        tick();
        chk("s1_first_addr", rel_addr_onehot_o, 16'h0001);
        chk("s1_first_id", rel_id_o, 4'd3);
        chk("model_pin_slot", m_slot, 0);
        tick();
        chk("s1_second_addr", rel_addr_onehot_o, 16'h0002);
        chk("s1_pulse0", released_addr_onehot_o, 16'h0001);
        chk("model_pin_pulse", m_pulse, 16'h0001);
        tick();
        chk("s1_pulse1", released_addr_onehot_o, 16'h0002);
        chk("s1_idle", rel_valid_o, 1'b0);
        chk("s1_free", free_slots_o, 16'hFFFB);

`ifdef SIMMEM_RELEASE_RR_EN
        do_reset();
        alloc(0, 1);
        alloc(5, 2);
        alloc(9, 3);
        release_en_mhot_i = 16'h0221;
        rel_ready_i       = 1'b1;
        tick();
        chk("rr_first", rel_addr_onehot_o, 16'h0001);
        tick();
        chk("rr_second", rel_addr_onehot_o, 16'h0020);
        tick();
        chk("rr_third", rel_addr_onehot_o, 16'h0200);
        tick();
        chk("rr_idle", rel_valid_o, 1'b0);
`else
        // Oldest-first across different IDs
        do_reset();
        alloc(4, 1);
        alloc(2, 2);
        release_en_mhot_i = 16'h0014;
        rel_ready_i       = 1'b1;
        tick();
        chk("s2_first_addr", rel_addr_onehot_o, 16'h0010);
        tick();
        chk("s2_pulse4", released_addr_onehot_o, 16'h0010);
        chk("s2_second_addr", rel_addr_onehot_o, 16'h0004);
        tick();
        chk("s2_pulse2", released_addr_onehot_o, 16'h0004);
        chk("s2_idle", rel_valid_o, 1'b0);
`endif

        // Hold under backpressure with enable withdrawn
        do_reset();
        alloc(7, 6);
        release_en_mhot_i = 16'h0080;
        rel_ready_i       = 1'b0;
        tick();
        chk("s3_present", rel_addr_onehot_o, 16'h0080);
        release_en_mhot_i = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s3_hold_addr", rel_addr_onehot_o, 16'h0080);
            chk("s3_hold_nopulse", released_addr_onehot_o, 16'h0000);
        end
        rel_ready_i = 1'b1;
        tick();
        chk("s3_pulse", released_addr_onehot_o, 16'h0080);
        chk("s3_idle", rel_valid_o, 1'b0);
        rel_ready_i = 1'b0;
        tick();
        chk("s3_single_pulse", released_addr_onehot_o, 16'h0000);

        // Full bank and illegal allocation
        do_reset();
        for (int i = 0; i < C; i++) alloc(i, i);
        chk("s4_full", free_slots_o, 16'h0000);
        alloc(3, 9);
        chk("s4_err", alloc_err_o, 1'b1);
        chk("s4_still_full", free_slots_o, 16'h0000);
        release_en_mhot_i = 16'h0008;
        tick();
        chk("s4_id_kept", rel_id_o, 4'd3);
        chk("s4_addr", rel_addr_onehot_o, 16'h0008);
        tick();
        chk("s4_err_sticky", alloc_err_o, 1'b1);

        // Asynchronous reset while holding
        rst_ni = 1'b0;
        #1;
        chk("s5_valid", rel_valid_o, 1'b0);
        chk("s5_addr", rel_addr_onehot_o, 16'h0000);
        chk("s5_id", rel_id_o, 4'd0);
        chk("s5_free", free_slots_o, 16'hFFFF);
        chk("s5_released", released_addr_onehot_o, 16'h0000);
        chk("s5_err", alloc_err_o, 1'b0);
        do_reset();
        tick();
        chk("s5_no_pulse", released_addr_onehot_o, 16'h0000);

        // Random traffic against the model
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int cyc = 0; cyc < 600; cyc++) begin
                alloc_valid_i       = 1'b0;
                alloc_addr_onehot_i = '0;
                alloc_id_i          = W'($urandom_range(3));
                if ($urandom_range(99) < 40) begin
                    tgt = -1;
                    if ((seg % 2 == 1) && ($urandom_range(99) < 3)) begin
                        tgt = int'($urandom_range(C - 1));
                    end else begin
                        start = int'($urandom_range(C - 1));
                        for (int k = 0; k < C; k++) begin
                            if (tgt < 0 && !m_valid[(start + k) % C]) tgt = (start + k) % C;
                        end
                    end
                    if (tgt >= 0) begin
                        alloc_valid_i       = 1'b1;
                        alloc_addr_onehot_i = onehot(tgt);
                    end
                end
                release_en_mhot_i = C'($urandom);
                rel_ready_i       = ($urandom_range(99) < 70);
                tick();
            end
        end

        clear_inputs();
        @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
